// File: rtl/traffic_gen_ld.sv
// traffic_gen_ld: fills the transaction-layer FIFO datapath with a numbered word stream, then drains it and checks the counts
// Ports:
//   clk, reset_L                      clock, asynchronous active-low reset
//   start, word_count, umbral_*_in    run request plus per-run word count and thresholds (sampled on accepted start)
//   pause, can_pop                    main-FIFO back-pressure, per-destination non-empty flags
//   push, data_out                    word offered to the datapath (push is combinational from pause)
//   init, umbral_mf/vc/d              configuration strobe and latched thresholds
//   pop                               per-destination pop (combinational from can_pop while draining)
//   busy, done, error                 status: not idle, end-of-run pulse, sticky mismatch/timeout
//   pushed_cnt, popped_cnt            running word totals
module traffic_gen_ld #(
  parameter int BITNUMBER     = 6,
  parameter int NUM_DEST      = 2,
  parameter int CNT_W         = 16,
  parameter int WAIT_CYCLES   = 50,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 start,
  input  logic [CNT_W-1:0]     word_count,
  input  logic [3:0]           umbral_mf_in,
  input  logic [3:0]           umbral_vc_in,
  input  logic [3:0]           umbral_d_in,
  input  logic                 pause,
  input  logic [NUM_DEST-1:0]  can_pop,
  output logic                 push,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 init,
  output logic [3:0]           umbral_mf,
  output logic [3:0]           umbral_vc,
  output logic [3:0]           umbral_d,
  output logic [NUM_DEST-1:0]  pop,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     pushed_cnt,
  output logic [CNT_W-1:0]     popped_cnt
);
  localparam int DW = $clog2(NUM_DEST);
  localparam int PW = BITNUMBER - DW - 1;
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_FILL, S_WAIT, S_DRAIN, S_DONE} state_t;
  state_t                r_state;
  logic [CNT_W-1:0]      r_word_count;
  logic [WW-1:0]         r_wait;
  logic [TW-1:0]         r_idle;
  logic [DW-1:0]         w_dest;
  logic [BITNUMBER-1:0]  w_next_word;
  logic [DW:0]           w_pop_n;
  logic [CNT_W:0]        w_pop_sum;
  logic [CNT_W-1:0]      w_popped_next;
  assign push = (r_state == S_FILL) && !pause;
  assign pop  = (r_state == S_DRAIN) ? can_pop : '0;
  assign w_dest = data_out[BITNUMBER-2 -: DW];
  // VC flips whenever the destination field wraps back to 0
  assign w_next_word = {data_out[BITNUMBER-1] ^ (w_dest == DW'(NUM_DEST - 1)), w_dest + 1'b1, data_out[PW-1:0] + 1'b1};
  always_comb begin
    w_pop_n = '0;
    for (int i = 0; i < NUM_DEST; i++) w_pop_n = w_pop_n + (DW+1)'(pop[i]);
  end
  assign w_pop_sum     = {1'b0, popped_cnt} + (CNT_W+1)'(w_pop_n);
  assign w_popped_next = w_pop_sum[CNT_W] ? '1 : w_pop_sum[CNT_W-1:0];
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= S_IDLE;
      r_word_count <= '0;
      r_wait       <= '0;
      r_idle       <= '0;
      data_out     <= '0;
      init         <= 1'b0;
      umbral_mf    <= '0;
      umbral_vc    <= '0;
      umbral_d     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      pushed_cnt   <= '0;
      popped_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state      <= S_CONFIG;
          r_word_count <= word_count;
          umbral_mf    <= umbral_mf_in;
          umbral_vc    <= umbral_vc_in;
          umbral_d     <= umbral_d_in;
          data_out     <= BITNUMBER'(1);
          pushed_cnt   <= '0;
          popped_cnt   <= '0;
          error        <= 1'b0;
          init         <= 1'b1;
          busy         <= 1'b1;
        end
        S_CONFIG: begin
          init    <= 1'b0;
          r_wait  <= '0;
          r_state <= (r_word_count == '0) ? S_WAIT : S_FILL;
        end
        S_FILL: if (push) begin
          pushed_cnt <= pushed_cnt + 1'b1;
          data_out   <= w_next_word;
          if (pushed_cnt + 1'b1 == r_word_count) r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wait <= r_wait + 1'b1;
          r_idle <= '0;
          if (r_wait == WW'(WAIT_CYCLES - 1)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          popped_cnt <= w_popped_next;
          r_idle     <= (pop == '0) ? r_idle + 1'b1 : '0;
          // an over-pop is flagged at once but the drain keeps running until it goes quiet
          if (w_popped_next > pushed_cnt) error <= 1'b1;
          if (w_popped_next == pushed_cnt) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else if (pop == '0 && r_idle == TW'(DRAIN_TIMEOUT - 1)) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            error   <= 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_traffic_gen_ld.sv
// tb_traffic_gen_ld: directed bench for traffic_gen_ld with a destination-FIFO occupancy model
module tb_traffic_gen_ld;
  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        start = 1'b0;
  logic [15:0] word_count = '0;
  logic [3:0]  umbral_mf_in = '0, umbral_vc_in = '0, umbral_d_in = '0;
  logic        pause = 1'b0;
  logic [1:0]  can_pop;
  logic        push, init, busy, done, error;
  logic [5:0]  data_out;
  logic [3:0]  umbral_mf, umbral_vc, umbral_d;
  logic [1:0]  pop;
  logic [15:0] pushed_cnt, popped_cnt;
  int checks = 0;
  int errors = 0;
  int cnt [2];
  int push_total = 0;
  int drop_at = -1;
  traffic_gen_ld dut (
    .clk(clk), .reset_L(reset_L), .start(start), .word_count(word_count),
    .umbral_mf_in(umbral_mf_in), .umbral_vc_in(umbral_vc_in), .umbral_d_in(umbral_d_in),
    .pause(pause), .can_pop(can_pop), .push(push), .data_out(data_out), .init(init),
    .umbral_mf(umbral_mf), .umbral_vc(umbral_vc), .umbral_d(umbral_d), .pop(pop),
    .busy(busy), .done(done), .error(error), .pushed_cnt(pushed_cnt), .popped_cnt(popped_cnt)
  );
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < 2; i++) can_pop[i] = cnt[i] != 0;
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) cnt[i] <= 0;
    end else begin
      if (push) push_total <= push_total + 1;
      for (int i = 0; i < 2; i++)
        cnt[i] <= cnt[i] + ((push && int'(data_out[4]) == i && push_total != drop_at) ? 1 : 0) - (pop[i] ? 1 : 0);
    end
  end
  function automatic logic [5:0] exp_word(int k);
    int j = k - 1;
    return {1'((j / 2) % 2), 1'(j % 2), 4'(k % 16)};
  endfunction
  task automatic do_start(input int wc, input logic [3:0] mf, input logic [3:0] vc, input logic [3:0] d);
    @(negedge clk);
    word_count = 16'(wc); umbral_mf_in = mf; umbral_vc_in = vc; umbral_d_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask
  task automatic fill_check(input string name, input int n, input int p0, input int plen);
    int k = 1;
    for (int c = 0; c < n + plen + 4 && k <= n; c++) begin
      @(negedge clk);
      pause = (c >= p0 && c < p0 + plen);
      #1;
      checks++;
      if (push !== !pause || data_out !== exp_word(k)) begin
        errors++;
        $display("FAIL %s word%0d cyc%0d: push=%b data=%b, want push=%b data=%b", name, k, c, push, data_out, !pause, exp_word(k));
      end
      if (!pause) k++;
    end
    @(negedge clk);
    pause = 1'b0;
    #1;
    checks++;
    if (push !== 1'b0 || pushed_cnt !== 16'(n)) begin
      errors++;
      $display("FAIL %s fill_end: push=%b pushed=%0d, want 0 %0d", name, push, pushed_cnt, n);
    end
  endtask
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = done;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: done=%b, want 1", name, done);
    end
  endtask
  task automatic test_reset;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = c[0];
    end
    #1;
    checks++;
    if ({push, init, busy, done, error, pop, data_out, pushed_cnt, popped_cnt, umbral_mf, umbral_vc, umbral_d} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: push=%b init=%b busy=%b done=%b err=%b data=%h", push, init, busy, done, error, data_out);
    end
    start = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || init !== 1'b0 || push !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b init=%b push=%b, want 0 0 0", busy, init, push);
    end
  endtask
  task automatic test_basic;
    int pushes0 = push_total;
    do_start(8, 4'd3, 4'd5, 4'd7);
    checks++;
    if (init !== 1'b1 || busy !== 1'b1 || umbral_mf !== 4'd3 || umbral_vc !== 4'd5 || umbral_d !== 4'd7 || data_out !== 6'b000001) begin
      errors++;
      $display("FAIL basic_config: init=%b busy=%b th=%h/%h/%h data=%b", init, busy, umbral_mf, umbral_vc, umbral_d, data_out);
    end
    fill_check("basic", 8, 100, 0);
    checks++;
    if (push_total - pushes0 !== 8) begin
      errors++;
      $display("FAIL basic_push_cycles: %0d, want 8", push_total - pushes0);
    end
    wait_done("basic");
    checks++;
    if (error !== 1'b0 || pushed_cnt !== 16'd8 || popped_cnt !== 16'd8 || umbral_mf !== 4'd3) begin
      errors++;
      $display("FAIL basic_result: err=%b pushed=%0d popped=%0d mf=%h, want 0 8 8 3", error, pushed_cnt, popped_cnt, umbral_mf);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cnt[0] !== 0 || cnt[1] !== 0) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b fifo=%0d/%0d, want 0 0 0 0", done, busy, cnt[0], cnt[1]);
    end
  endtask
  task automatic test_backpressure;
    do_start(8, 4'd1, 4'd2, 4'd3);
    fill_check("pause", 8, 3, 3);
    wait_done("pause");
    checks++;
    if (error !== 1'b0 || popped_cnt !== 16'd8) begin
      errors++;
      $display("FAIL pause_result: err=%b popped=%0d, want 0 8", error, popped_cnt);
    end
  endtask
  task automatic test_lost_word;
    drop_at = push_total + 3;
    do_start(8, 4'd2, 4'd2, 4'd2);
    fill_check("lost", 8, 100, 0);
    wait_done("lost");
    checks++;
    if (error !== 1'b1 || pushed_cnt !== 16'd8 || popped_cnt !== 16'd7) begin
      errors++;
      $display("FAIL lost_result: err=%b pushed=%0d popped=%0d, want 1 8 7", error, pushed_cnt, popped_cnt);
    end
    drop_at = -1;
  endtask
  task automatic test_zero_words;
    do_start(0, 4'd6, 4'd6, 4'd6);
    checks++;
    if (init !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL zero_config: init=%b err=%b, want 1 0", init, error);
    end
    @(negedge clk);
    #1;
    checks++;
    if (push !== 1'b0 || busy !== 1'b1 || init !== 1'b0) begin
      errors++;
      $display("FAIL zero_skip_fill: push=%b busy=%b init=%b, want 0 1 0", push, busy, init);
    end
    wait_done("zero");
    checks++;
    if (error !== 1'b0 || pushed_cnt !== 16'd0 || popped_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zero_result: err=%b pushed=%0d popped=%0d, want 0 0 0", error, pushed_cnt, popped_cnt);
    end
  endtask
  task automatic test_wrap_and_busy_start;
    do_start(20, 4'd10, 4'd11, 4'd12);
    fill_check("wrap", 20, 100, 0);
    do_start(3, 4'd9, 4'd9, 4'd9);
    checks++;
    if (init !== 1'b0 || umbral_mf !== 4'd10 || pushed_cnt !== 16'd20) begin
      errors++;
      $display("FAIL busy_start: init=%b mf=%h pushed=%0d, want 0 a 20", init, umbral_mf, pushed_cnt);
    end
    wait_done("wrap");
    checks++;
    if (error !== 1'b0 || popped_cnt !== 16'd20 || umbral_d !== 4'd12) begin
      errors++;
      $display("FAIL wrap_result: err=%b popped=%0d d=%h, want 0 20 c", error, popped_cnt, umbral_d);
    end
  endtask
  task automatic test_mid_reset;
    bit in_drain = 0;
    do_start(8, 4'd4, 4'd4, 4'd4);
    fill_check("midrst", 8, 100, 0);
    for (int c = 0; c < 200 && !in_drain; c++) begin
      @(negedge clk);
      #1;
      in_drain = popped_cnt != 0;
    end
    checks++;
    if (!in_drain) begin
      errors++;
      $display("FAIL midrst_reach_drain: popped=%0d, want >0", popped_cnt);
    end
    #2 reset_L = 1'b0;
    #1;
    checks++;
    if ({push, init, busy, done, error, pop, data_out, pushed_cnt, popped_cnt, umbral_mf} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b pop=%b data=%h pushed=%0d popped=%0d", busy, pop, data_out, pushed_cnt, popped_cnt);
    end
    @(negedge clk);
    reset_L = 1'b1;
    do_start(4, 4'd8, 4'd8, 4'd8);
    checks++;
    if (error !== 1'b0 || init !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart: err=%b init=%b, want 0 1", error, init);
    end
    fill_check("midrst2", 4, 100, 0);
    wait_done("midrst2");
    checks++;
    if (error !== 1'b0 || pushed_cnt !== 16'd4 || popped_cnt !== 16'd4) begin
      errors++;
      $display("FAIL midrst_result: err=%b pushed=%0d popped=%0d, want 0 4 4", error, pushed_cnt, popped_cnt);
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_lost_word;
    test_zero_words;
    test_wrap_and_busy_start;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_gen_ld.md
# traffic_gen_ld

Synthesizable, parametrised traffic generator and drain controller for the transaction-layer FIFO datapath (main FIFO, VC0/VC1 FIFOs and the D0..Dn destination FIFOs). Its handshake is back-pressure safe: a word offered while the main FIFO signals pause is held, not dropped, and is pushed once pause clears. After the fill phase the block drains every destination FIFO and checks that the number of words popped equals the number pushed. It sits in front of the datapath's push/data_in/init/threshold inputs and behind its pause/can_pop outputs.

## Interface
- BITNUMBER, 6: data word width; bit BITNUMBER-1 = VC select.
- NUM_DEST, 2: number of destination FIFOs, power of 2, ≥2; DW = log2(NUM_DEST).
- CNT_W, 16: word/pop counter width.
- WAIT_CYCLES, 50: idle cycles between end of fill and start of drain.
- DRAIN_TIMEOUT, 64: consecutive pop-less drain cycles before abort.

- clk  in  1  rising-edge clock.
- reset_L  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run a sequence; honoured only in IDLE.
- word_count  in  CNT_W  words to push; sampled on accepted start.
- umbral_mf_in, umbral_vc_in, umbral_d_in  in  4 each  thresholds; sampled on accepted start.
- pause  in  1  main-FIFO back-pressure.
- can_pop  in  NUM_DEST  per-destination non-empty flags.
- push  out  1  data_out valid and accepted this cycle.
- data_out  out  BITNUMBER  word to datapath.
- init  out  1  configuration strobe.
- umbral_mf, umbral_vc, umbral_d  out  4 each  latched thresholds.
- pop  out  NUM_DEST  per-destination pop.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle end-of-sequence pulse.
- error  out  1  sticky mismatch/timeout flag, cleared on next accepted start.
- pushed_cnt, popped_cnt  out  CNT_W each  running totals.

## Operation
- States: IDLE → CONFIG → FILL → WAIT → DRAIN → DONE → IDLE.
- IDLE: start=1 latches word_count and thresholds, clears counters and error, loads the first word, goes to CONFIG. start in any other state is ignored.
- CONFIG: one cycle. init=1. Threshold outputs stay stable from this cycle until the next accepted start.
- FILL: push = !pause (combinational). On each cycle with push=1, pushed_cnt increments and the next word is loaded into data_out. When pause=1, data_out is held.
  - Leave FILL on the edge where pushed_cnt reaches word_count.
  - word_count=0 skips FILL and goes to WAIT.
- Word format:
  - payload = data_out[BITNUMBER-DW-2:0]: starts at 1, increments per word, wraps modulo its width.
  - dest field = data_out[BITNUMBER-2 -: DW]: starts at 0, rotates 0..NUM_DEST-1.
  - VC bit: starts at 0, toggles each time dest wraps back to 0.
- WAIT: counts WAIT_CYCLES cycles, then goes to DRAIN.
- DRAIN: pop[i] = can_pop[i] (combinational). popped_cnt increases by popcount(pop) per cycle (width saturated to CNT_W).
  - popped_cnt == pushed_cnt → DONE.
  - DRAIN_TIMEOUT consecutive cycles with pop==0 → DONE with error=1.
  - popped_cnt > pushed_cnt → error=1 immediately, drain continues until the timeout.
- DONE: done=1 for one cycle, then IDLE.
- Reset (asynchronous, any time, including mid-FILL or mid-DRAIN): state IDLE; all outputs 0; counters, thresholds and data_out = 0.

## Timing
- Accepted start at edge N: init=1 in cycle N+1; FILL begins N+2, with data_out already holding the first word.
- push and pop are combinational from pause and can_pop; all other outputs are registered.
- Full-rate throughput: one word per cycle with no pause; fill takes word_count cycles.
- Pause asserted in cycle k: push=0 in cycle k and the same word is re-offered in cycle k+1. No word is skipped or duplicated.
- Drain: popped_cnt updates on the edge after each pop cycle. done is asserted the cycle after the matching edge.

## Test plan
- Reset/idle: hold reset_L=0, toggle start → all outputs 0, busy=0. Release reset → still idle until start.
- Basic run, NUM_DEST=2, word_count=8, pause=0:
  - data_out sequence 000001, 010010, 100011, 110100, 000101, ...
  - init high exactly one cycle; 8 push cycles.
  - Datapath model drains 8 words → done pulse, error=0, pushed_cnt=popped_cnt=8.
- Back-pressure: pause=1 for 3 cycles mid-fill → push low for those 3 cycles, data_out frozen. Fill completes with 8 distinct consecutive payloads.
- Lost word: model drops one word → popped_cnt=7. After DRAIN_TIMEOUT pop-less cycles → done with error=1.
- Edge cases:
  - word_count=0 → CONFIG, WAIT, DRAIN, done with error=0.
  - start while busy → ignored.
  - word_count=20 → payload wraps 15→0.
- Mid-operation reset: reset_L low during DRAIN → immediate IDLE with outputs 0. A new start then runs a clean sequence with error cleared.
